// File: rtl/traffic_sequencer.sv
// traffic_sequencer: powers, times and monitors one traffic light FSM.
// Optional TRAFFIC_SEQ_AUTORESTART_EN: timed retry after a fault.
module traffic_sequencer #(
  parameter int         G_TIME      = 8,
  parameter int         Y_TIME      = 3,
  parameter int         R_TIME      = 6,
  parameter int         PED_MIN     = 2,
  parameter int         ACK_TIMEOUT = 4,
  parameter int         CW          = 8,
  parameter logic [1:0] ST_G        = 2'b01,
  parameter logic [1:0] ST_Y        = 2'b10,
  parameter logic [1:0] ST_R        = 2'b11
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       PED_REQ,
  input  logic       G,
  input  logic       Y,
  input  logic       R,
  input  logic [1:0] CURST,
  output logic       POW,
  output logic       STR,
  output logic       PED_ACK,
  output logic       FAULT,
  output logic [1:0] FAULT_CODE
);

  typedef enum logic [2:0] {
    IDLE, PWRUP, DWELL, PULSE, WAIT_ACK, FLT
  } state_e;

  localparam logic [CW-1:0] PM1 = CW'(PED_MIN - 1);
  localparam logic [CW-1:0] TMO = CW'(ACK_TIMEOUT - 1);

  state_e        state_q;
  logic [1:0]    phase_q;
  logic [1:0]    code_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] tmo_q;
  logic          ped_q;
  logic          req_q;
  logic          bad_q;
  logic          pow_q;
  logic          str_q;
  logic          ack_q;
  logic          flt_q;
`ifdef TRAFFIC_SEQ_AUTORESTART_EN
  logic [3:0]    hold_q;
  logic [1:0]    retry_q;
`endif

  logic       vlit;
  logic       new_ph;
  logic       ped_eff;
  logic       chk;
  logic       enter;
  logic       f01;
  logic       f11;
  logic       f10;
  logic       fhit;
  logic [1:0] fcode;

  function automatic logic [CW-1:0] dwell_ld(input logic [1:0] s);
    if (s == ST_G) return CW'(G_TIME - 1);
    if (s == ST_Y) return CW'(Y_TIME - 1);
    return CW'(R_TIME - 1);
  endfunction

  always_comb begin
    vlit = ({G, Y, R} == 3'b100 && CURST == ST_G) ||
           ({G, Y, R} == 3'b010 && CURST == ST_Y) ||
           ({G, Y, R} == 3'b001 && CURST == ST_R);
    new_ph  = vlit && (CURST != phase_q);
    ped_eff = ped_q | (PED_REQ & ~req_q);
    chk     = (state_q == DWELL) || (state_q == PULSE) ||
              (state_q == WAIT_ACK);
    enter   = (state_q == PWRUP && vlit) ||
              (state_q == WAIT_ACK && new_ph);
    f01 = chk && !vlit && bad_q;
    f11 = (state_q == DWELL) && new_ph;
    f10 = (state_q == PWRUP && !vlit && tmo_q >= TMO) ||
          (state_q == WAIT_ACK && !new_ph && tmo_q >= TMO);
    fhit = f01 | f11 | f10;
    if (f01)      fcode = 2'b01;
    else if (f11) fcode = 2'b11;
    else          fcode = 2'b10;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      phase_q <= 2'b00;
      code_q  <= 2'b00;
      cnt_q   <= '0;
      tmo_q   <= '0;
      ped_q   <= 1'b0;
      req_q   <= 1'b0;
      bad_q   <= 1'b0;
      pow_q   <= 1'b0;
      str_q   <= 1'b0;
      ack_q   <= 1'b0;
      flt_q   <= 1'b0;
`ifdef TRAFFIC_SEQ_AUTORESTART_EN
      hold_q  <= '0;
      retry_q <= '0;
`endif
    end else begin
      req_q <= PED_REQ;
      str_q <= 1'b0;
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          pow_q  <= 1'b0;
          ped_q  <= 1'b0;
          flt_q  <= 1'b0;
          code_q <= 2'b00;
`ifdef TRAFFIC_SEQ_AUTORESTART_EN
          retry_q <= '0;
`endif
          if (EN) begin
            state_q <= PWRUP;
            pow_q   <= 1'b1;
            tmo_q   <= '0;
          end
        end
        FLT: begin
          if (!EN) begin
            state_q <= IDLE;
            flt_q   <= 1'b0;
            code_q  <= 2'b00;
          end
`ifdef TRAFFIC_SEQ_AUTORESTART_EN
          else if (retry_q != 2'd3) begin
            if (hold_q == 4'd15) begin
              state_q <= PWRUP;
              pow_q   <= 1'b1;
              flt_q   <= 1'b0;
              tmo_q   <= '0;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
`endif
        end
        default: begin
          if (!EN) begin
            state_q <= IDLE;
            pow_q   <= 1'b0;
            ped_q   <= 1'b0;
            bad_q   <= 1'b0;
          end else if (fhit) begin
            state_q <= FLT;
            pow_q   <= 1'b0;
            flt_q   <= 1'b1;
            code_q  <= fcode;
            ped_q   <= 1'b0;
            bad_q   <= 1'b0;
`ifdef TRAFFIC_SEQ_AUTORESTART_EN
            hold_q  <= '0;
            retry_q <= retry_q + 1'b1;
`endif
          end else begin
            ped_q <= ped_eff;
            bad_q <= ~vlit;
            if (enter) begin
              state_q <= DWELL;
              phase_q <= CURST;
              cnt_q   <= dwell_ld(CURST);
              // Crossing is granted as red begins
              if (CURST == ST_R && ped_eff) begin
                ack_q <= 1'b1;
                ped_q <= 1'b0;
              end
`ifdef TRAFFIC_SEQ_AUTORESTART_EN
              if (phase_q == ST_R && CURST == ST_G) retry_q <= '0;
`endif
            end else begin
              unique case (state_q)
                DWELL: begin
                  if (phase_q == ST_G && ped_eff && cnt_q > PM1) begin
                    cnt_q <= PM1;
                  end else if (cnt_q == '0) begin
                    state_q <= PULSE;
                    str_q   <= 1'b1;
                    tmo_q   <= '0;
                  end else begin
                    cnt_q <= cnt_q - 1'b1;
                  end
                end
                PULSE: begin
                  state_q <= WAIT_ACK;
                  tmo_q   <= tmo_q + 1'b1;
                end
                default: tmo_q <= tmo_q + 1'b1;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign POW        = pow_q;
  assign STR        = str_q;
  assign PED_ACK    = ack_q;
  assign FAULT      = flt_q;
  assign FAULT_CODE = code_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// tb_traffic_sequencer: directed vectors against a simple light model.
// Model light: lights green one cycle after seeing POW, advances on STR.
module tb_traffic_sequencer;

  localparam logic [1:0] SG = 2'b01;
  localparam logic [1:0] SY = 2'b10;
  localparam logic [1:0] SR = 2'b11;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       EN;
  logic       PED_REQ;
  logic       G;
  logic       Y;
  logic       R;
  logic [1:0] CURST;
  logic       POW;
  logic       STR;
  logic       PED_ACK;
  logic       FAULT;
  logic [1:0] FAULT_CODE;

  int checks  = 0;
  int errors  = 0;
  int cyc_n   = 0;
  int str_cnt = 0;
  int ack_cnt = 0;
  int flt_cnt = 0;

  logic [1:0] lst;
  // 0 normal, 1 G+Y glitch, 2 forced Y, 3 ignore STR, 4 dark
  logic [2:0] inj;

  always #5 CLK = ~CLK;

  traffic_sequencer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .PED_REQ    (PED_REQ),
    .G          (G),
    .Y          (Y),
    .R          (R),
    .CURST      (CURST),
    .POW        (POW),
    .STR        (STR),
    .PED_ACK    (PED_ACK),
    .FAULT      (FAULT),
    .FAULT_CODE (FAULT_CODE)
  );

  typedef struct {
    int         n;
    logic       en;
    logic       ped;
    logic [2:0] inj;
    logic       pow;
    logic       stb;
    logic       ack;
    logic       flt;
    logic [1:0] code;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int n, logic en, logic ped, logic [2:0] ij,
                              logic pw, logic sb, logic ak, logic ft,
                              logic [1:0] cd);
    vec_t v;
    v.n = n; v.en = en; v.ped = ped; v.inj = ij;
    v.pow = pw; v.stb = sb; v.ack = ak; v.flt = ft; v.code = cd;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic drive_light();
    G = (lst == SG);
    Y = (lst == SY);
    R = (lst == SR);
    CURST = lst;
    case (inj)
      3'd1: Y = 1'b1;
      3'd2: begin G = 1'b0; Y = 1'b1; R = 1'b0; CURST = SY; end
      3'd4: begin G = 1'b0; Y = 1'b0; R = 1'b0; CURST = 2'b00; end
      default: ;
    endcase
  endtask

  task automatic cyc();
    logic p, s;
    p = POW;
    s = STR;
    @(posedge CLK);
    #1;
    cyc_n++;
    if (!p) lst = 2'b00;
    else if (lst == 2'b00) lst = SG;
    else if (s && inj != 3'd3)
      lst = (lst == SG) ? SY : (lst == SY) ? SR : SG;
    drive_light();
    if (STR) str_cnt++;
    if (PED_ACK) ack_cnt++;
    if (FAULT) flt_cnt++;
  endtask

  task automatic run_rows(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      EN = tv[i].en;
      PED_REQ = tv[i].ped;
      inj = tv[i].inj;
      drive_light();
      repeat (tv[i].n) cyc();
      chk($sformatf("row%0d.pow", i), 8'(POW), 8'(tv[i].pow));
      chk($sformatf("row%0d.str", i), 8'(STR), 8'(tv[i].stb));
      chk($sformatf("row%0d.ack", i), 8'(PED_ACK), 8'(tv[i].ack));
      chk($sformatf("row%0d.flt", i), 8'(FAULT), 8'(tv[i].flt));
      chk($sformatf("row%0d.code", i), 8'(FAULT_CODE), 8'(tv[i].code));
    end
  endtask

  task automatic restart_dark();
    RST_N = 1'b0;
    lst = 2'b00;
    inj = 3'd4;
    EN = 1'b1;
    PED_REQ = 1'b0;
    drive_light();
    @(negedge CLK);
    RST_N = 1'b1;
    cyc_n = 0;
  endtask

  initial begin
    // healthy run; comments give the cycle each row lands on
    tv.push_back(mk( 1, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 1  PWRUP
    tv.push_back(mk( 9, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 10 last G dwell
    tv.push_back(mk( 1, 1, 0, 0, 1, 1, 0, 0, 2'd0)); // 11 STR
    tv.push_back(mk( 1, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 12
    tv.push_back(mk( 4, 1, 0, 0, 1, 1, 0, 0, 2'd0)); // 16 STR after Y
    tv.push_back(mk( 1, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 17
    tv.push_back(mk( 6, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 23
    tv.push_back(mk( 1, 1, 0, 0, 1, 1, 0, 0, 2'd0)); // 24 STR after R
    tv.push_back(mk(10, 1, 0, 0, 1, 1, 0, 0, 2'd0)); // 34
    tv.push_back(mk(23, 1, 0, 0, 1, 1, 0, 0, 2'd0)); // 57
    tv.push_back(mk(13, 1, 0, 0, 1, 1, 0, 0, 2'd0)); // 70
    // pedestrian request while green count is 6
    tv.push_back(mk( 3, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 73
    tv.push_back(mk( 1, 1, 1, 0, 1, 0, 0, 0, 2'd0)); // 74 cnt=1
    tv.push_back(mk( 1, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 75
    tv.push_back(mk( 1, 1, 0, 0, 1, 1, 0, 0, 2'd0)); // 76 STR
    tv.push_back(mk( 6, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 82
    tv.push_back(mk( 1, 1, 0, 0, 1, 0, 1, 0, 2'd0)); // 83 ACK
    tv.push_back(mk( 1, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 84
    tv.push_back(mk( 1, 1, 1, 0, 1, 0, 0, 0, 2'd0)); // 85 req in red
    tv.push_back(mk( 4, 1, 0, 0, 1, 1, 0, 0, 2'd0)); // 89
    tv.push_back(mk( 5, 1, 0, 0, 1, 1, 0, 0, 2'd0)); // 94 short green
    tv.push_back(mk( 6, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 100
    tv.push_back(mk( 1, 1, 0, 0, 1, 0, 1, 0, 2'd0)); // 101 ACK
    tv.push_back(mk( 1, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 102
    // light stuck at yellow
    tv.push_back(mk(16, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 118
    tv.push_back(mk( 4, 1, 0, 3, 1, 1, 0, 0, 2'd0)); // 122 STR
    tv.push_back(mk( 3, 1, 0, 3, 1, 0, 0, 0, 2'd0)); // 125
    tv.push_back(mk( 1, 1, 0, 3, 0, 0, 0, 1, 2'd2)); // 126 timeout
    tv.push_back(mk( 3, 1, 0, 3, 0, 0, 0, 1, 2'd2)); // 129 held
    tv.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 0, 2'd0)); // 130 IDLE
    // lamp glitches during green dwell
    tv.push_back(mk( 5, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 135
    tv.push_back(mk( 1, 1, 0, 1, 1, 0, 0, 0, 2'd0)); // 136 one bad
    tv.push_back(mk( 1, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 137
    tv.push_back(mk( 2, 1, 0, 1, 0, 0, 0, 1, 2'd1)); // 139 two bad
    tv.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 0, 2'd0)); // 140
    // unsolicited G->Y in dwell
    tv.push_back(mk( 5, 1, 0, 0, 1, 0, 0, 0, 2'd0)); // 145
    tv.push_back(mk( 1, 1, 0, 2, 0, 0, 0, 1, 2'd3)); // 146
    tv.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 0, 2'd0)); // 147

    RST_N = 1'b0;
    EN = 1'b1;
    PED_REQ = 1'b0;
    inj = 3'd0;
    lst = 2'b00;
    drive_light();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.pow", 8'(POW), 8'd0);
    chk("rst.str", 8'(STR), 8'd0);
    chk("rst.ack", 8'(PED_ACK), 8'd0);
    chk("rst.flt", 8'(FAULT), 8'd0);
    chk("rst.code", 8'(FAULT_CODE), 8'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    run_rows(0, 24);
    chk("str_count", 8'(str_cnt), 8'd14);
    chk("ack_count", 8'(ack_cnt), 8'd2);
    chk("fault_cycles", 8'(flt_cnt), 8'd0);
    run_rows(24, tv.size());

    // async reset while STR is high
    EN = 1'b1;
    inj = 3'd0;
    drive_light();
    for (int k = 0; k < 40 && !STR; k++) cyc();
    chk("pulse_seen", 8'(STR), 8'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst.str", 8'(STR), 8'd0);
    chk("arst.pow", 8'(POW), 8'd0);
    chk("arst.flt", 8'(FAULT), 8'd0);
    lst = 2'b00;
    drive_light();
    @(negedge CLK);
    RST_N = 1'b1;
    cyc();
    chk("arst.repwr", 8'(POW), 8'd1);

    // dark light: power-up timeout
    restart_dark();
    repeat (4) cyc();
    chk("pwr_tmo.c4", 8'(FAULT), 8'd0);
    cyc();
    chk("pwr_tmo.flt", 8'(FAULT), 8'd1);
    chk("pwr_tmo.code", 8'(FAULT_CODE), 8'd2);
    chk("pwr_tmo.pow", 8'(POW), 8'd0);
`ifdef TRAFFIC_SEQ_AUTORESTART_EN
    repeat (15) cyc();
    chk("ar.c20.flt", 8'(FAULT), 8'd1);
    chk("ar.c20.pow", 8'(POW), 8'd0);
    cyc();
    chk("ar.c21.pow", 8'(POW), 8'd1);
    chk("ar.c21.flt", 8'(FAULT), 8'd0);
    chk("ar.c21.code", 8'(FAULT_CODE), 8'd2);
    repeat (4) cyc();
    chk("ar.c25.flt", 8'(FAULT), 8'd1);
    repeat (16) cyc();
    chk("ar.c41.pow", 8'(POW), 8'd1);
    repeat (4) cyc();
    chk("ar.c45.flt", 8'(FAULT), 8'd1);
    repeat (25) cyc();
    chk("ar.latch.flt", 8'(FAULT), 8'd1);
    chk("ar.latch.pow", 8'(POW), 8'd0);
`else
    repeat (25) cyc();
    chk("latch.flt", 8'(FAULT), 8'd1);
    chk("latch.pow", 8'(POW), 8'd0);
    chk("latch.code", 8'(FAULT_CODE), 8'd2);
`endif
    EN = 1'b0;
    cyc();
    chk("exit.flt", 8'(FAULT), 8'd0);
    chk("exit.code", 8'(FAULT_CODE), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_sequencer.md
Name: traffic_sequencer

Overview:
- Initiator-side controller for the `traffic` light FSM.
- Drives the FSM's POW and STR inputs and reads back its G, Y, R and CURST outputs.
- Times each light phase and services pedestrian requests.
- Checks the light's responses and shuts the light down on a fault.
- Sits between the intersection supervisor (EN, PED_REQ) and one `traffic` instance.

Parameters:
- G_TIME, 8: green dwell in cycles (≥1).
- Y_TIME, 3: yellow dwell in cycles (≥1).
- R_TIME, 6: red dwell in cycles (≥1).
- PED_MIN, 2: maximum remaining green after a pedestrian request (≥1).
- ACK_TIMEOUT, 4: cycles allowed for the light to respond to POW or STR.
- CW, 8: dwell counter width; every *_TIME and PED_MIN must be < 2^CW.
- ST_G, 2'b01 / ST_Y, 2'b10 / ST_R, 2'b11: CURST encodings for the lit states; any other value means off.

Ports:
- CLK, in, 1: clock; all logic is rising-edge.
- RST_N, in, 1: asynchronous active-low reset.
- EN, in, 1: run request from the supervisor.
- PED_REQ, in, 1: level pedestrian request.
- G, in, 1: green lamp from the light.
- Y, in, 1: yellow lamp from the light.
- R, in, 1: red lamp from the light.
- CURST, in, 2: light state from the light.
- POW, out, 1: power to the light.
- STR, out, 1: one-cycle advance pulse to the light.
- PED_ACK, out, 1: one-cycle pulse acknowledging a pedestrian request.
- FAULT, out, 1: fault flag.
- FAULT_CODE, out, 2: fault cause; 00 none, 01 lamp mismatch, 10 response timeout, 11 unsolicited state change.

Behaviour:
- Reset values: POW=0, STR=0, PED_ACK=0, FAULT=0, FAULT_CODE=00. The FSM resets to IDLE, all counters to 0, the pedestrian latch is cleared.
- "Valid lit" means exactly one of G/Y/R is high, it matches CURST, and CURST is one of ST_G, ST_Y, ST_R.
- IDLE:
  - POW=0.
  - EN=1 → PWRUP.
- PWRUP:
  - POW=1; the timeout counter counts.
  - The first valid-lit cycle latches phase=CURST, loads the dwell counter with the phase time minus 1, and goes to DWELL.
  - No valid-lit state within ACK_TIMEOUT cycles → FAULT, code 10.
- DWELL:
  - Counter decrements each cycle.
  - At 0 → PULSE.
  - A green phase therefore lasts exactly G_TIME cycles in DWELL; yellow and red behave the same with Y_TIME and R_TIME.
- PULSE:
  - STR=1 for exactly one cycle, then → WAIT_ACK.
- WAIT_ACK:
  - First valid-lit cycle with CURST≠phase: latch the new phase, reload the counter, → DWELL.
  - CURST still equal to phase after ACK_TIMEOUT cycles → FAULT, code 10.
- Pedestrian requests:
  - A PED_REQ rising edge sets the pedestrian latch. A request during the latch-set period is absorbed.
  - While phase=ST_G in DWELL with the latch set, if counter > PED_MIN-1 it is loaded with PED_MIN-1. This is evaluated every DWELL cycle, so shortening is never skipped.
  - On entry to a phase=ST_R DWELL with the latch set: PED_ACK=1 for one cycle and the latch clears.
  - A request in Y or R is held until the next red after a green.
- Fault checks, active in DWELL, PULSE and WAIT_ACK:
  - Not valid-lit for 2 consecutive cycles → code 01.
  - In DWELL, CURST≠phase while valid-lit → code 11.
  - If several conditions hit in the same cycle, priority is 01 > 11 > 10.
- FAULT state:
  - POW=0, STR=0, FAULT=1, FAULT_CODE held.
  - Leaves to IDLE only when EN=0; FAULT and FAULT_CODE clear on that exit.
- EN=0 in any non-FAULT state:
  - Next cycle → IDLE, POW=0.
  - An in-flight STR pulse completes; the latch clears.
- RST_N low mid-operation: all outputs return to reset values asynchronously.
- EN held high from reset: POW rises on the first clock edge after reset release.

Optional Feature:
- Macro: TRAFFIC_SEQ_AUTORESTART_EN.
- When defined:
  - FAULT runs a hold counter of 16 cycles with POW=0.
  - After the hold, if EN=1 the block goes to PWRUP, FAULT clears, and FAULT_CODE is retained until the next fault or EN=0.
  - After 3 consecutive faults without a completed R→G cycle, the fault latches as in the non-macro behaviour.
- When undefined: FAULT is latched until EN=0; no hold counter and no retry counter are built.

Test Plan:
- Healthy light, EN=1 from reset:
  - POW=1 at cycle 1.
  - Light reports G, so STR pulses after 8 DWELL cycles.
  - Y follows, then STR after 3 cycles.
  - R follows, then STR after 6 cycles.
  - FAULT stays 0 over 3 full cycles.
- PED_REQ pulse at green DWELL count 6:
  - Counter drops to 1; STR is issued 2 cycles later.
  - PED_ACK pulses once on red entry.
  - A second PED_REQ in red is held and acknowledged only at the following red.
- Light ignores STR with CURST stuck at ST_Y:
  - 4 cycles after STR, FAULT=1, FAULT_CODE=10, POW=0.
  - EN=0 returns to IDLE with FAULT=0.
- Fault injection during DWELL:
  - G and Y both high for 2 cycles → FAULT_CODE=01.
  - A 1-cycle glitch does not fault.
- CURST changes G→Y mid-DWELL with no STR → FAULT_CODE=11.
- RST_N asserted during PULSE:
  - STR, POW and FAULT are 0 immediately, before the next clock edge.
  - After release with EN=1, the block re-enters PWRUP.
  - With TRAFFIC_SEQ_AUTORESTART_EN: a timeout fault re-powers the light after 16 cycles, and the third consecutive fault latches.
